sad_accum_min: RTL and testbench

SAD_ACCUM_MIN -- requirements
Module: sad_accum_min

---
 rtl/sad_accum_min.sv | 125 ++++++++++++
 tb/tb_sad_accum_min.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_accum_min.sv
// sad_accum_min: accumulates per-candidate SAD over ROWS beats of LANES abs-diff values and
// tracks the minimum across a search. Define SAD_TIE_LATEST_EN to let the latest equal SAD win.
module sad_accum_min #(
    parameter int PIXEL  = 8,
    parameter int LANES  = 8,
    parameter int ROWS   = 8,
    parameter int CAND_W = 10,
    localparam int SW    = PIXEL + $clog2(LANES * ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CAND_W-1:0]        num_cand,
    input  logic                     abs_valid,
    input  logic [LANES*PIXEL-1:0]   abs_in,
    output logic                     busy,
    output logic                     cand_valid,
    output logic [SW-1:0]            cand_sad,
    output logic                     done,
    output logic [SW-1:0]            best_sad,
    output logic [CAND_W-1:0]        best_idx
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CAND_W-1:0] num_q;
    logic [CAND_W-1:0] cand_cnt;
    logic [RW-1:0]     row_cnt;
    logic [SW-1:0]     acc;
    logic [SW-1:0]     rowsum;
    logic [SW-1:0]     sad_next;
    logic              beat;
    logic              last_row;
    logic              last_cand;
    logic              better;

    always_comb begin
        rowsum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            rowsum = rowsum + SW'(abs_in[i*PIXEL +: PIXEL]);
        end
    end

    // start has priority over a coincident beat, so an aborted search never absorbs it
    assign beat      = (state == ACCUM) && abs_valid && !start;
    assign last_row  = (row_cnt == RW'(ROWS - 1));
    assign last_cand = (cand_cnt == (num_q - CAND_W'(1)));
    assign sad_next  = acc + rowsum;

`ifdef SAD_TIE_LATEST_EN
    assign better = (sad_next <= best_sad);
`else
    assign better = (sad_next < best_sad);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state == ACCUM);
        done       = (state == DONE);
        if (start) begin
            state_next = (num_cand == '0) ? DONE : ACCUM;
        end else begin
            case (state)
                ACCUM:   if (beat && last_row && last_cand) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q      <= '0;
            cand_cnt   <= '0;
            row_cnt    <= '0;
            acc        <= '0;
            cand_sad   <= '0;
            cand_valid <= 1'b0;
            best_sad   <= '1;
            best_idx   <= '0;
        end else begin
            cand_valid <= 1'b0;
            if (start) begin
                num_q    <= num_cand;
                cand_cnt <= '0;
                row_cnt  <= '0;
                acc      <= '0;
                best_sad <= '1;
                best_idx <= '0;
            end else if (beat) begin
                if (last_row) begin
                    cand_sad   <= sad_next;
                    cand_valid <= 1'b1;
                    acc        <= '0;
                    row_cnt    <= '0;
                    cand_cnt   <= cand_cnt + CAND_W'(1);
                    if (better) begin
                        best_sad <= sad_next;
                        best_idx <= cand_cnt;
                    end
                end else begin
                    acc     <= sad_next;
                    row_cnt <= row_cnt + RW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_accum_min.sv
// Self-checking bench for sad_accum_min: beat-count reference model compared every cycle,
// plus directed literal scenarios and randomized searches with aborts and resets.
module tb_sad_accum_min;
    localparam int PIXEL  = 8;
    localparam int LANES  = 8;
    localparam int ROWS   = 8;
    localparam int CAND_W = 10;
    localparam int SW     = PIXEL + $clog2(LANES * ROWS);
    localparam int unsigned ALL1 = (1 << SW) - 1;
`ifdef SAD_TIE_LATEST_EN
    localparam int unsigned TIE_IDX = 2;
`else
    localparam int unsigned TIE_IDX = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [CAND_W-1:0]      num_cand = '0;
    logic                   abs_valid = 1'b0;
    logic [LANES*PIXEL-1:0] abs_in = '0;
    logic                   busy, cand_valid, done;
    logic [SW-1:0]          cand_sad, best_sad;
    logic [CAND_W-1:0]      best_idx;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int done_seen = 0;
    int cv_seen = 0;

    // reference model: search progress expressed as a running beat count
    bit          m_active, m_done, m_cv;
    int unsigned m_cand_sad, m_best, m_idx, m_n, m_beats, m_sum;

    always #5 clk = ~clk;

    sad_accum_min #(
        .PIXEL (PIXEL),
        .LANES (LANES),
        .ROWS  (ROWS),
        .CAND_W(CAND_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_cand  (num_cand),
        .abs_valid (abs_valid),
        .abs_in    (abs_in),
        .busy      (busy),
        .cand_valid(cand_valid),
        .cand_sad  (cand_sad),
        .done      (done),
        .best_sad  (best_sad),
        .best_idx  (best_idx)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit wins(input int unsigned sad, input int unsigned best);
`ifdef SAD_TIE_LATEST_EN
        return sad <= best;
`else
        return sad < best;
`endif
    endfunction

    function automatic logic [LANES*PIXEL-1:0] fill(input int unsigned val);
        logic [PIXEL-1:0] p;
        p = val[PIXEL-1:0];
        return {LANES{p}};
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_cv = 0;
        m_cand_sad = 0; m_best = ALL1; m_idx = 0;
        m_n = 0; m_beats = 0; m_sum = 0;
    endtask

    task automatic model_step(input bit s, input int unsigned n, input bit v,
                              input logic [LANES*PIXEL-1:0] d);
        m_done = 0;
        m_cv   = 0;
        if (s) begin
            m_n = n; m_beats = 0; m_sum = 0; m_best = ALL1; m_idx = 0;
            m_active = (n != 0);
            m_done   = (n == 0);
        end else if (m_active && v) begin
            for (int i = 0; i < LANES; i++) m_sum += d[i*PIXEL +: PIXEL];
            m_beats++;
            if (m_beats % ROWS == 0) begin
                m_cv = 1;
                m_cand_sad = m_sum;
                if (wins(m_sum, m_best)) begin
                    m_best = m_sum;
                    m_idx  = m_beats / ROWS - 1;
                end
                m_sum = 0;
                if (m_beats / ROWS == m_n) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit s, input int unsigned n, input bit v, input logic [LANES*PIXEL-1:0] d);
        start = s; num_cand = n[CAND_W-1:0]; abs_valid = v; abs_in = d;
        @(posedge clk);
        model_step(s, n, v, d);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        @(negedge clk); #1;
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cand_valid"}, cand_valid, 0);
        chk({tag, "_cand_sad"}, cand_sad, 0);
        chk({tag, "_best_sad"}, best_sad, 16383);
        chk({tag, "_best_idx"}, best_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("cand_valid", cand_valid, m_cv);
            chk("cand_sad", cand_sad, m_cand_sad);
            chk("best_sad", best_sad, m_best);
            chk("best_idx", best_idx, m_idx);
            if (done) done_seen++;
            if (cand_valid) cv_seen++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_cv, base_done, budget;
        bit tie;
        int unsigned n;

        model_reset();
        chk_en = 1'b1;
        do_reset("por");

        // three equal candidates of all-ones lanes
        base_cv = cv_seen;
        cyc(1, 3, 0, '0);
        for (int i = 0; i < 24; i++) cyc(0, 0, 1, fill(1));
        @(negedge clk); #1;
        chk("t1_done", done, 1);
        chk("t1_cand_sad", cand_sad, 64);
        chk("t1_best_sad", best_sad, 64);
        chk("t1_best_idx", best_idx, TIE_IDX);
        chk("t1_cv_count", cv_seen - base_cv, 3);
        cyc(0, 0, 0, '0);

        // maximum SAD then zero
        cyc(1, 2, 0, '0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, fill(255));
        @(negedge clk); #1;
        chk("t2_cand0_sad", cand_sad, 16320);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, fill(0));
        @(negedge clk); #1;
        chk("t2_cand1_sad", cand_sad, 0);
        chk("t2_best_sad", best_sad, 0);
        chk("t2_best_idx", best_idx, 1);
        chk("t2_done", done, 1);

        // valid beats every other cycle with junk data on the gaps
        cyc(1, 2, 0, '0);
        for (int k = 0; k < 16; k++) begin
            cyc(0, 0, 0, fill(9));
            cyc(0, 0, 1, fill(k < 8 ? 5 : 3));
        end
        @(negedge clk); #1;
        chk("t3_done", done, 1);
        chk("t3_best_sad", best_sad, 192);
        chk("t3_best_idx", best_idx, 1);
        cyc(0, 0, 0, '0);

        // abort after 5 rows, then a fresh single-candidate search
        base_done = done_seen;
        cyc(1, 2, 0, '0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, fill(2));
        cyc(1, 1, 0, '0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, fill(2));
        @(negedge clk); #1;
        chk("t4_done", done, 1);
        chk("t4_best_sad", best_sad, 128);
        chk("t4_best_idx", best_idx, 0);
        chk("t4_done_count", done_seen - base_done, 1);
        cyc(0, 0, 0, '0);

        // empty search, then stray beats while idle
        base_cv = cv_seen;
        cyc(1, 0, 1, fill(4));
        @(negedge clk); #1;
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_best_sad", best_sad, 16383);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, fill(7));
        chk("t5_no_cv", cv_seen - base_cv, 0);

        // reset mid-search
        base_done = done_seen;
        cyc(1, 3, 0, '0);
        for (int i = 0; i < 11; i++) cyc(0, 0, 1, fill(6));
        do_reset("midrst");
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, fill(6));
        chk("midrst_no_done", done_seen - base_done, 0);

        // randomized searches with occasional aborts, resets and frequent ties
        for (int t = 0; t < 60; t++) begin
            n = $urandom_range(0, 4);
            tie = ($urandom_range(0, 2) == 0);
            cyc(1, n, 0, '0);
            budget = 0;
            while (m_active && budget < 400) begin
                logic [LANES*PIXEL-1:0] d;
                bit v;
                v = ($urandom_range(0, 3) != 0);
                d = tie ? fill($urandom_range(0, 1)) : {$urandom, $urandom};
                if ($urandom_range(0, 199) == 0) cyc(1, $urandom_range(1, 3), v, d);
                else if ($urandom_range(0, 499) == 0) do_reset("rand_rst");
                else cyc(0, 0, v, d);
                budget++;
            end
            chk("rand_search_ends", busy, 0);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                cyc(0, 0, $urandom_range(0, 1), {$urandom, $urandom});
        end

        cyc(0, 0, 0, '0);
        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
